// File: rtl/ice40_io_pkg.sv
// Shared mode encodings for the iCE40-style I/O cell.
// PIN_TYPE layout: [5:4] OE mode, [3:2] output data mode, [1:0] input mode.
package ice40_io_pkg;

  localparam logic [1:0] OE_NEVER  = 2'b00;
  localparam logic [1:0] OE_ALWAYS = 2'b01;
  localparam logic [1:0] OE_DIRECT = 2'b10;
  localparam logic [1:0] OE_REG    = 2'b11;

  localparam logic [1:0] DATA_DDR     = 2'b00;
  localparam logic [1:0] DATA_REG     = 2'b01;
  localparam logic [1:0] DATA_DIRECT  = 2'b10;
  localparam logic [1:0] DATA_REG_INV = 2'b11;

  localparam logic [1:0] IN_REG       = 2'b00;
  localparam logic [1:0] IN_DIRECT    = 2'b01;
  localparam logic [1:0] IN_REG_LATCH = 2'b10;
  localparam logic [1:0] IN_LATCH     = 2'b11;

  localparam logic [5:0] PIN_TYPE_DEFAULT = 6'b1010_01;

endpackage

// File: rtl/ice40_io_bit.sv
// Single-pin slice of the I/O cell: OE, output data and input path for one pad.
module ice40_io_bit
  import ice40_io_pkg::*;
#(
  parameter logic [5:0] PIN_TYPE    = PIN_TYPE_DEFAULT,
  parameter bit         PULLUP      = 1'b0,
  parameter bit         NEG_TRIGGER = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clock_enable,
  input  logic latch_input_value,
  input  logic output_enable,
  input  logic d_out_0,
  input  logic d_out_1,
  output logic d_in_0,
  output logic d_in_1,
  inout  wire  pad
);

  localparam logic [1:0] OE_MODE   = PIN_TYPE[5:4];
  localparam logic [1:0] DATA_MODE = PIN_TYPE[3:2];
  localparam logic [1:0] IN_MODE   = PIN_TYPE[1:0];

  // aclk is high during the phase that follows the active edge.
  logic aclk;
  assign aclk = clk ^ NEG_TRIGGER;

  logic oe_q, q0, q1, in0_q, in1_q, lat_q;
  logic pin_in, drive, data, in_hold;

  assign pin_in  = pad;
  assign in_hold = (IN_MODE == IN_REG_LATCH) && latch_input_value;

  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      oe_q  <= 1'b0;
      q0    <= 1'b0;
      in0_q <= 1'b0;
    end else if (clock_enable) begin
      oe_q <= output_enable;
      q0   <= d_out_0;
      if (!in_hold) in0_q <= pin_in;
    end
  end

  always_ff @(negedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      q1    <= 1'b0;
      in1_q <= 1'b0;
    end else if (clock_enable) begin
      q1 <= d_out_1;
      if (!in_hold) in1_q <= pin_in;
    end
  end

  // Transparent input latch; closes while latch_input_value is high.
  always_latch begin
    if (!rst_n) lat_q <= 1'b0;
    else if (!latch_input_value) lat_q <= pin_in;
  end

  always_comb begin
    drive = 1'b0;
    case (OE_MODE)
      OE_NEVER:  drive = 1'b0;
      OE_ALWAYS: drive = 1'b1;
      OE_DIRECT: drive = output_enable;
      OE_REG:    drive = oe_q;
      default:   drive = 1'b0;
    endcase
  end

  always_comb begin
    data = 1'b0;
    case (DATA_MODE)
      DATA_DDR:     data = aclk ? q0 : q1;
      DATA_REG:     data = q0;
      DATA_DIRECT:  data = d_out_0;
      DATA_REG_INV: data = ~q0;
      default:      data = 1'b0;
    endcase
  end

  assign pad = drive ? data : 1'bz;

  generate
    if (PULLUP) begin : g_pullup
      pullup pu (pad);
    end
  endgenerate

  always_comb begin
    d_in_0 = 1'b0;
    d_in_1 = 1'b0;
    case (IN_MODE)
      IN_REG, IN_REG_LATCH: begin
        d_in_0 = in0_q;
        d_in_1 = in1_q;
      end
      IN_DIRECT: d_in_0 = pin_in;
      IN_LATCH:  d_in_0 = lat_q;
      default:   d_in_0 = 1'b0;
    endcase
  end

endmodule

// File: rtl/ice40_io_cell.sv
// SB_IO-style bidirectional I/O cell, WIDTH independent pins sharing one configuration.
module ice40_io_cell
  import ice40_io_pkg::*;
#(
  parameter logic [5:0] PIN_TYPE    = PIN_TYPE_DEFAULT,
  parameter bit         PULLUP      = 1'b0,
  parameter bit         NEG_TRIGGER = 1'b0,
  parameter int         WIDTH       = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clock_enable,
  input  logic             latch_input_value,
  input  logic             output_enable,
  input  logic [WIDTH-1:0] d_out_0,
  input  logic [WIDTH-1:0] d_out_1,
  output logic [WIDTH-1:0] d_in_0,
  output logic [WIDTH-1:0] d_in_1,
  inout  wire  [WIDTH-1:0] package_pin
);

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      ice40_io_bit #(
        .PIN_TYPE   (PIN_TYPE),
        .PULLUP     (PULLUP),
        .NEG_TRIGGER(NEG_TRIGGER)
      ) u_bit (
        .clk              (clk),
        .rst_n            (rst_n),
        .clock_enable     (clock_enable),
        .latch_input_value(latch_input_value),
        .output_enable    (output_enable),
        .d_out_0          (d_out_0[gi]),
        .d_out_1          (d_out_1[gi]),
        .d_in_0           (d_in_0[gi]),
        .d_in_1           (d_in_1[gi]),
        .pad              (package_pin[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_ice40_io_cell.sv
// Directed bench for ice40_io_cell: several configurations share control inputs, each has its own pin net.
module tb_ice40_io_cell;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clock_enable;
  logic       latch_input_value;
  logic       output_enable;
  logic [7:0] d_out_0;
  logic [7:0] d_out_1;

  logic       ext_a_en, ext_b_en;
  logic [7:0] ext_a;
  logic       ext_b, ext_e;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Default configuration, 8 pins; pulldown makes an undriven pin read 0.
  wire  [7:0] pin_a;
  logic [7:0] a_d_in_0, a_d_in_1;
  assign pin_a = ext_a_en ? ext_a : 8'bz;
  pulldown pd_a (pin_a);

  // Never drive, direct input, internal pullup.
  wire  pin_b;
  logic b_d_in_0, b_d_in_1;
  assign pin_b = ext_b_en ? ext_b : 1'bz;

  // Registered OE, registered data, registered input.
  wire  pin_c;
  logic c_d_in_0, c_d_in_1;
  pulldown pd_c (pin_c);

  // Always drive, DDR data, direct input.
  wire  pin_d;
  logic d_d_in_0, d_d_in_1;

  // Never drive, input latch; pin driven by the bench.
  wire  pin_e;
  logic e_d_in_0, e_d_in_1;
  assign pin_e = ext_e;

  ice40_io_cell #(.PIN_TYPE(6'b1010_01), .PULLUP(1'b0), .NEG_TRIGGER(1'b0), .WIDTH(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .clock_enable(clock_enable), .latch_input_value(latch_input_value),
    .output_enable(output_enable), .d_out_0(d_out_0), .d_out_1(d_out_1),
    .d_in_0(a_d_in_0), .d_in_1(a_d_in_1), .package_pin(pin_a));

  ice40_io_cell #(.PIN_TYPE(6'b0010_01), .PULLUP(1'b1), .NEG_TRIGGER(1'b0), .WIDTH(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .clock_enable(clock_enable), .latch_input_value(latch_input_value),
    .output_enable(output_enable), .d_out_0(d_out_0[0:0]), .d_out_1(d_out_1[0:0]),
    .d_in_0(b_d_in_0), .d_in_1(b_d_in_1), .package_pin(pin_b));

  ice40_io_cell #(.PIN_TYPE(6'b1101_00), .PULLUP(1'b0), .NEG_TRIGGER(1'b0), .WIDTH(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .clock_enable(clock_enable), .latch_input_value(latch_input_value),
    .output_enable(output_enable), .d_out_0(d_out_0[0:0]), .d_out_1(d_out_1[0:0]),
    .d_in_0(c_d_in_0), .d_in_1(c_d_in_1), .package_pin(pin_c));

  ice40_io_cell #(.PIN_TYPE(6'b0100_01), .PULLUP(1'b0), .NEG_TRIGGER(1'b0), .WIDTH(1)) dut_d (
    .clk(clk), .rst_n(rst_n), .clock_enable(clock_enable), .latch_input_value(latch_input_value),
    .output_enable(output_enable), .d_out_0(d_out_0[0:0]), .d_out_1(d_out_1[0:0]),
    .d_in_0(d_d_in_0), .d_in_1(d_d_in_1), .package_pin(pin_d));

  ice40_io_cell #(.PIN_TYPE(6'b0010_11), .PULLUP(1'b0), .NEG_TRIGGER(1'b0), .WIDTH(1)) dut_e (
    .clk(clk), .rst_n(rst_n), .clock_enable(clock_enable), .latch_input_value(latch_input_value),
    .output_enable(output_enable), .d_out_0(d_out_0[0:0]), .d_out_1(d_out_1[0:0]),
    .d_in_0(e_d_in_0), .d_in_1(e_d_in_1), .package_pin(pin_e));

  task automatic test_reset();
    rst_n = 1'b0; clock_enable = 1'b1; latch_input_value = 1'b0; output_enable = 1'b0;
    d_out_0 = 8'h00; d_out_1 = 8'h00;
    ext_a_en = 1'b0; ext_a = 8'h00; ext_b_en = 1'b0; ext_b = 1'b0; ext_e = 1'b0;
    #3;
    checks++; if (c_d_in_0 !== 1'b0) begin errors++; $display("FAIL reset_c_din0: got %b want 0", c_d_in_0); end
    checks++; if (c_d_in_1 !== 1'b0) begin errors++; $display("FAIL reset_c_din1: got %b want 0", c_d_in_1); end
    checks++; if (pin_c !== 1'b0) begin errors++; $display("FAIL reset_c_pin_released: got %b want 0 (pulled)", pin_c); end
    checks++; if (a_d_in_0 !== 8'h00) begin errors++; $display("FAIL reset_a_din0: got %h want 00", a_d_in_0); end
    $display("[%0t] reset checks done", $time);
    @(negedge clk); #2;
    rst_n = 1'b1;
  endtask

  task automatic test_direct_out();
    logic [7:0] pats [4] = '{8'hA5, 8'h00, 8'hFF, 8'h5A};
    output_enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d_out_0 = pats[i];
      #1;
      checks++; if (pin_a !== pats[i]) begin errors++; $display("FAIL direct_pin[%0d]: got %h want %h", i, pin_a, pats[i]); end
      checks++; if (a_d_in_0 !== pats[i]) begin errors++; $display("FAIL direct_loopback[%0d]: got %h want %h", i, a_d_in_0, pats[i]); end
      $display("[%0t] direct out %h -> pin %h din0 %h", $time, pats[i], pin_a, a_d_in_0);
    end
    checks++; if (a_d_in_1 !== 8'h00) begin errors++; $display("FAIL direct_din1: got %h want 00", a_d_in_1); end
  endtask

  task automatic test_external();
    output_enable = 1'b0;
    #1;
    checks++; if (pin_a !== 8'h00) begin errors++; $display("FAIL ext_released: got %h want 00 (pulled)", pin_a); end
    ext_a = 8'h3C; ext_a_en = 1'b1;
    #1;
    checks++; if (pin_a !== 8'h3C) begin errors++; $display("FAIL ext_pin: got %h want 3c", pin_a); end
    checks++; if (a_d_in_0 !== 8'h3C) begin errors++; $display("FAIL ext_din0: got %h want 3c", a_d_in_0); end
    $display("[%0t] external drive 3c -> pin %h din0 %h", $time, pin_a, a_d_in_0);
    ext_a_en = 1'b0;
  endtask

  task automatic test_pullup();
    #1;
    checks++; if (b_d_in_0 !== 1'b1) begin errors++; $display("FAIL pullup_float: got %b want 1", b_d_in_0); end
    ext_b = 1'b0; ext_b_en = 1'b1;
    #1;
    checks++; if (b_d_in_0 !== 1'b0) begin errors++; $display("FAIL pullup_override: got %b want 0", b_d_in_0); end
    $display("[%0t] pullup pin reads %b when driven low", $time, b_d_in_0);
    ext_b_en = 1'b0;
  endtask

  task automatic test_registered();
    @(negedge clk); #2;
    rst_n = 1'b0; output_enable = 1'b1; d_out_0 = 8'h01;
    #1; rst_n = 1'b1; #1;
    checks++; if (pin_c !== 1'b0) begin errors++; $display("FAIL reg_oe_before_edge: got %b want 0 (released)", pin_c); end
    @(posedge clk); #2;
    checks++; if (pin_c !== 1'b1) begin errors++; $display("FAIL reg_pin_first_edge: got %b want 1", pin_c); end
    checks++; if (c_d_in_0 !== 1'b0) begin errors++; $display("FAIL reg_din0_first_edge: got %b want 0", c_d_in_0); end
    @(negedge clk); #2;
    checks++; if (c_d_in_1 !== 1'b1) begin errors++; $display("FAIL reg_din1_other_edge: got %b want 1", c_d_in_1); end
    @(posedge clk); #2;
    checks++; if (c_d_in_0 !== 1'b1) begin errors++; $display("FAIL reg_din0_second_edge: got %b want 1", c_d_in_0); end
    d_out_0 = 8'h00;
    #1;
    checks++; if (pin_c !== 1'b1) begin errors++; $display("FAIL reg_data_holds: got %b want 1", pin_c); end
    @(posedge clk); #2;
    checks++; if (pin_c !== 1'b0) begin errors++; $display("FAIL reg_data_update: got %b want 0", pin_c); end
    d_out_0 = 8'h01;
    @(posedge clk); #2;
    checks++; if (pin_c !== 1'b1) begin errors++; $display("FAIL reg_data_back: got %b want 1", pin_c); end
    $display("[%0t] registered path pin %b din0 %b din1 %b", $time, pin_c, c_d_in_0, c_d_in_1);
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #2;
    checks++; if (c_d_in_0 !== 1'b1) begin errors++; $display("FAIL pre_reset_din0: got %b want 1", c_d_in_0); end
    rst_n = 1'b0;
    #1;
    checks++; if (pin_c !== 1'b0) begin errors++; $display("FAIL midreset_pin_released: got %b want 0 (pulled)", pin_c); end
    checks++; if (c_d_in_0 !== 1'b0) begin errors++; $display("FAIL midreset_din0: got %b want 0", c_d_in_0); end
    checks++; if (c_d_in_1 !== 1'b0) begin errors++; $display("FAIL midreset_din1: got %b want 0", c_d_in_1); end
    $display("[%0t] mid-operation reset pin %b din0 %b", $time, pin_c, c_d_in_0);
    @(negedge clk); #2;
    rst_n = 1'b1;
  endtask

  task automatic test_ddr();
    d_out_0 = 8'h01; d_out_1 = 8'h00; clock_enable = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #2;
      checks++; if (pin_d !== 1'b1) begin errors++; $display("FAIL ddr_high[%0d]: got %b want 1", i, pin_d); end
      checks++; if (d_d_in_0 !== 1'b1) begin errors++; $display("FAIL ddr_loop_high[%0d]: got %b want 1", i, d_d_in_0); end
      @(negedge clk); #2;
      checks++; if (pin_d !== 1'b0) begin errors++; $display("FAIL ddr_low[%0d]: got %b want 0", i, pin_d); end
      $display("[%0t] ddr cycle %0d ok-sampled pin %b", $time, i, pin_d);
    end
    d_out_1 = 8'h01;
    @(posedge clk); #2;
    @(negedge clk); #2;
    checks++; if (pin_d !== 1'b1) begin errors++; $display("FAIL ddr_q1_capture: got %b want 1", pin_d); end
    clock_enable = 1'b0; d_out_0 = 8'h00; d_out_1 = 8'h00;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #2;
      checks++; if (pin_d !== 1'b1) begin errors++; $display("FAIL ddr_ce_hold_high[%0d]: got %b want 1", i, pin_d); end
      @(negedge clk); #2;
      checks++; if (pin_d !== 1'b1) begin errors++; $display("FAIL ddr_ce_hold_low[%0d]: got %b want 1", i, pin_d); end
      $display("[%0t] ddr frozen cycle %0d pin %b", $time, i, pin_d);
    end
    clock_enable = 1'b1;
    @(posedge clk); #2;
    checks++; if (pin_d !== 1'b0) begin errors++; $display("FAIL ddr_ce_resume: got %b want 0", pin_d); end
  endtask

  task automatic test_latch();
    latch_input_value = 1'b0; ext_e = 1'b0;
    #1;
    checks++; if (e_d_in_0 !== 1'b0) begin errors++; $display("FAIL latch_open: got %b want 0", e_d_in_0); end
    latch_input_value = 1'b1;
    #1; ext_e = 1'b1; #1;
    checks++; if (e_d_in_0 !== 1'b0) begin errors++; $display("FAIL latch_hold: got %b want 0", e_d_in_0); end
    @(posedge clk); #2;
    checks++; if (e_d_in_0 !== 1'b0) begin errors++; $display("FAIL latch_hold_edge: got %b want 0", e_d_in_0); end
    latch_input_value = 1'b0;
    #1;
    checks++; if (e_d_in_0 !== 1'b1) begin errors++; $display("FAIL latch_release: got %b want 1", e_d_in_0); end
    checks++; if (e_d_in_1 !== 1'b0) begin errors++; $display("FAIL latch_din1: got %b want 0", e_d_in_1); end
    $display("[%0t] latch released din0 %b", $time, e_d_in_0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got no finish want finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_direct_out();
    test_external();
    test_pullup();
    test_registered();
    test_reset_mid();
    test_ddr();
    test_latch();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
